// File: rtl/scan_multi_pkg.sv
// Shared definitions for the multiplexed display scanner: enable polarity
// type, index-width helper and polarity mapping helper.
package scan_multi_pkg;

    localparam int MAX_DIGITS = 8;

    typedef enum logic {
        EN_POL_HIGH = 1'b0,
        EN_POL_LOW  = 1'b1
    } en_pol_e;

    // Number of bits needed to hold values 0..value-1, never less than one.
    function automatic int clog2_min1(input int value);
        int w;
        int v;
        w = 0;
        v = value - 1;
        while (v > 0) begin
            w = w + 1;
            v = v >> 1;
        end
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

    // Maps a logical "digit enabled" bit onto the physical enable level.
    function automatic logic en_level(input en_pol_e pol, input logic active);
        return (pol == EN_POL_LOW) ? ~active : active;
    endfunction

endpackage

// File: rtl/scan_multi_prescaler.sv
// Divides the system clock down to the per-digit step rate: tick_o is high
// on the last clock of every DIV-clock window.
module scan_prescaler
    import scan_multi_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic clrn,
    output logic tick_o
);

    localparam int            CW   = clog2_min1(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] pre_cnt_q;
    logic [CW-1:0] pre_cnt_d;

    // Next count: wrap to zero after the last clock of the window.
    always_comb begin
        if (pre_cnt_q == LAST) begin
            pre_cnt_d = '0;
        end else begin
            pre_cnt_d = pre_cnt_q + CW'(1);
        end
    end

    // Prescaler counter register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

    assign tick_o = (pre_cnt_q == LAST);

endmodule

// File: rtl/scan_multi.sv
// Time-multiplexed display scanner. Steps through DIGITS digits, each held
// for DIV clocks, with frame-synchronous capture of the digit codes, decimal
// points, blink mask and leading-zero enable so a frame never tears.
module scan_multi
    import scan_multi_pkg::*;
#(
    parameter int DIGITS       = 3,
    parameter int DIV          = 1,
    parameter int BLINK_FRAMES = 64,
    parameter int EN_LOW       = 0
) (
    input  logic                  clk,
    input  logic                  clrn,
    input  logic [4*DIGITS-1:0]   datain,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic                  blank_lz,
    output logic [3:0]            scan_data,
    output logic [DIGITS-1:0]     scan_en,
    output logic                  scan_dp,
    output logic                  frame_tick
);

    localparam int                IW         = clog2_min1(DIGITS);
    localparam logic [IW-1:0]     LAST_IDX   = IW'(DIGITS - 1);
    localparam int                FW         = clog2_min1(BLINK_FRAMES);
    localparam logic [FW-1:0]     LAST_FRAME = FW'(BLINK_FRAMES - 1);
    localparam en_pol_e           POL        = (EN_LOW != 0) ? EN_POL_LOW : EN_POL_HIGH;
    localparam logic [DIGITS-1:0] EN_OFF     = (EN_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic                  tick_s;
    logic                  load_s;

    logic [IW-1:0]         idx_q,        idx_d;
    logic [4*DIGITS-1:0]   shadow_q,     shadow_d;
    logic [DIGITS-1:0]     dp_sh_q,      dp_sh_d;
    logic [DIGITS-1:0]     mask_sh_q,    mask_sh_d;
    logic                  lz_sh_q,      lz_sh_d;
    logic                  primed_q,     primed_d;
    logic                  blink_on_q,   blink_on_d;
    logic [FW-1:0]         frame_cnt_q,  frame_cnt_d;

    logic [DIGITS-1:0]     zero_sfx_s;
    logic [DIGITS-1:0]     blank_s;
    logic [3:0]            data_mux_s;
    logic                  dp_mux_s;
    logic                  vis_s;

    logic [DIGITS-1:0]     en_q,         en_d;
    logic [3:0]            data_q,       data_d;
    logic                  dp_q,         dp_d;
    logic                  frame_tick_q, frame_tick_d;

    scan_prescaler #(
        .DIV    (DIV)
    ) u_prescaler (
        .clk    (clk),
        .clrn   (clrn),
        .tick_o (tick_s)
    );

    // The very first clock after reset captures so the display never shows
    // stale shadow contents for a full frame; afterwards capture coincides
    // with the tick that wraps the index back to digit 0.
    assign load_s = ~primed_q | (tick_s & (idx_q == LAST_IDX));

    // Next state for the digit index, shadow registers and blink timer.
    always_comb begin
        if (tick_s) begin
            if (idx_q == LAST_IDX) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end else begin
            idx_d = idx_q;
        end

        if (load_s) begin
            shadow_d  = datain;
            dp_sh_d   = dp_in;
            mask_sh_d = blink_mask;
            lz_sh_d   = blank_lz;
        end else begin
            shadow_d  = shadow_q;
            dp_sh_d   = dp_sh_q;
            mask_sh_d = mask_sh_q;
            lz_sh_d   = lz_sh_q;
        end

        primed_d = primed_q | load_s;

        // The initial capture only primes the shadows; it is not a frame
        // boundary for blink timing.
        if (load_s && primed_q) begin
            if (frame_cnt_q == LAST_FRAME) begin
                frame_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                frame_cnt_d = frame_cnt_q + FW'(1);
                blink_on_d  = blink_on_q;
            end
        end else begin
            frame_cnt_d = frame_cnt_q;
            blink_on_d  = blink_on_q;
        end
    end

    // Suffix-OR of the shadow nibbles from the most significant digit down:
    // zero_sfx_s[i] is set when nibbles i..DIGITS-1 are all zero.
    always_comb begin : lz_suffix
        logic run_zero;
        run_zero   = 1'b1;
        zero_sfx_s = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run_zero      = run_zero & (shadow_q[4*i +: 4] == 4'h0);
            zero_sfx_s[i] = run_zero;
        end
    end

    // Per-digit darkening: leading-zero blanking (never digit 0) or blink-off.
    always_comb begin
        blank_s = '0;
        for (int i = 0; i < DIGITS; i++) begin
            blank_s[i] = (lz_sh_q & (i != 0) & zero_sfx_s[i])
                       | (mask_sh_q[i] & ~blink_on_q);
        end
    end

    // Select the code, decimal point and visibility of the current digit.
    always_comb begin
        data_mux_s = 4'h0;
        dp_mux_s   = 1'b0;
        vis_s      = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            data_mux_s = data_mux_s | (shadow_q[4*i +: 4] & {4{idx_q == IW'(i)}});
            dp_mux_s   = dp_mux_s   | (dp_sh_q[i]  & (idx_q == IW'(i)));
            vis_s      = vis_s      | (~blank_s[i] & (idx_q == IW'(i)));
        end
    end

    // Output next values; data is still driven while the digit is dark.
    always_comb begin
        en_d = EN_OFF;
        for (int i = 0; i < DIGITS; i++) begin
            en_d[i] = en_level(POL, vis_s & (idx_q == IW'(i)));
        end
        data_d       = data_mux_s;
        dp_d         = dp_mux_s & vis_s;
        frame_tick_d = load_s;
    end

    // Scanner state and registered outputs.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            idx_q        <= '0;
            shadow_q     <= '0;
            dp_sh_q      <= '0;
            mask_sh_q    <= '0;
            lz_sh_q      <= 1'b0;
            primed_q     <= 1'b0;
            blink_on_q   <= 1'b1;
            frame_cnt_q  <= '0;
            en_q         <= EN_OFF;
            data_q       <= 4'h0;
            dp_q         <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            dp_sh_q      <= dp_sh_d;
            mask_sh_q    <= mask_sh_d;
            lz_sh_q      <= lz_sh_d;
            primed_q     <= primed_d;
            blink_on_q   <= blink_on_d;
            frame_cnt_q  <= frame_cnt_d;
            en_q         <= en_d;
            data_q       <= data_d;
            dp_q         <= dp_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign scan_en    = en_q;
    assign scan_data  = data_q;
    assign scan_dp    = dp_q;
    assign frame_tick = frame_tick_q;

endmodule
